vga_vblank_arbiter: RTL and testbench
=====================================

// Module: vga_vblank_arbiter
// PURPOSE
//  Shares the frame-buffer write port between N_REQ drawing engines during vertical blanking only.
//  Sits beside the 1280x720 timing generator (1650x750 totals, vblank lines 720..749), clocked by pclk.
//  Emits a frame-start strobe and a frame counter. Grants the port round-robin, one owner at a time.
//  Revokes a grant on release, timeout, or end of vblank. Engines never write while pixels are visible.
// PARAMETERS
//  N_REQ       4     number of requesters (2..8)
//  TIMEOUT     4096  max pclk cycles one grant may be held (>=2)
//  GUARD_LINE  748   no new grant is issued while vcount >= GUARD_LINE
// PORTS
//  pclk         in   1      pixel clock; all logic on rising edge
//  rst          in   1      asynchronous, active-high reset
//  vcount       in   11     line counter from timing generator
//  vblnk        in   1      vertical blank from timing generator
//  req          in   N_REQ  level requests, one per engine
//  done         in   N_REQ  release strobes; only the granted bit is honoured
//  grant        out  N_REQ  registered one-hot grant (all zero when idle)
//  busy         out  1      registered; high while any grant bit is set
//  abort        out  1      one-cycle pulse when a grant is revoked without done
//  frame_start  out  1      one-cycle pulse on the cycle after vblnk rises
//  frame_cnt    out  16     frames started, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, rst=1): grant=0, busy=0, abort=0, frame_start=0, frame_cnt=0.
//   Also vblnk_d=0, rr_ptr=N_REQ-1 (req[0] wins first), timer=0, state=DISPLAY.
//  Edge detect: vs_rise = vblnk & ~vblnk_d. vblnk_d is a register.
//   vs_rise=1 on the first cycle after reset while vblnk is high -> treat as a frame start.
//  On vs_rise: frame_start=1 on the next cycle; frame_cnt increments on the same edge.
//  FSM states (2-bit): DISPLAY, SELECT, GRANTED, DRAIN.
//   DISPLAY: grant=0. vs_rise -> SELECT.
//   SELECT: checks in priority order:
//    ~vblnk -> DISPLAY.
//    vcount>=GUARD_LINE -> DRAIN.
//    |req -> pick the first set req starting at rr_ptr+1 (mod N_REQ).
//     Register grant one-hot. rr_ptr=winner. timer=0. -> GRANTED.
//    Request-to-grant latency: 1 cycle from SELECT entry.
//    No req: stay in SELECT.
//   GRANTED: timer increments each cycle. Release causes, highest priority first:
//    a) done[winner] -> grant=0 next cycle, abort=0.
//    b) ~vblnk -> grant=0, abort=1 for one cycle.
//    c) timer==TIMEOUT-1 -> grant=0, abort=1 for one cycle.
//    After release: next state is SELECT if vblnk still high, else DISPLAY.
//    Max grant length is exactly TIMEOUT cycles.
//   DRAIN: grant=0. ~vblnk -> DISPLAY.
//  Boundary cases:
//   done and vblnk fall in the same cycle -> clean release (a), no abort.
//   done on a non-granted bit, or while idle -> ignored.
//   req dropped while granted does not release; only done/timeout/vblank end release.
//   vs_rise while in GRANTED is impossible (vblnk is high); no special case needed.
//   busy == |grant at all times, both registered.
//  Arithmetic: timer is $clog2(TIMEOUT) bits. rr_ptr is $clog2(N_REQ) bits, wraps N_REQ-1 -> 0.
// STRUCTURE
//  vga_pkg: timing constants (H/V totals, blank and sync starts) and the FSM state encoding.
//  Sub-module vga_rr_pick: combinational round-robin picker.
//   Inputs: req, rr_ptr. Outputs: one-hot winner, index, any.
//  Top level holds the FSM, timer, edge detect and frame counter.
// TESTING
//  1 Reset while rst=1 mid-grant -> all outputs 0 immediately.
//    After release, req=4'b0001 during vblank -> grant=0001.
//  2 vblnk rises at vcount=720 -> frame_start pulses exactly once, frame_cnt 0->1.
//    Preload frame_cnt=16'hFFFF -> wraps to 0.
//  3 req=4'b1111, each done strobed 3 cycles after its grant -> grants 0001,0010,0100,1000,0001.
//    busy low for exactly 1 cycle between grants.
//  4 req=4'b0100, done never asserted, TIMEOUT=16 -> grant high for 16 cycles, then abort pulses once.
//    req still high -> 0100 is re-granted after a 1-cycle gap.
//  5 Grant held when vblnk falls at vcount=0 -> grant=0 and abort=1 next cycle, state DISPLAY.
//    Same stimulus with done in the same cycle -> abort stays 0.
//  6 req first asserted at vcount=748 -> no grant this frame.
//    Grant issued in the next frame's vblank; done to a non-granted bit has no effect.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: 1280x720 timing constants and arbiter FSM encoding.
// Shared by the vblank arbiter and its round-robin picker.
package vga_pkg;

  localparam int H_ACTIVE      = 1280;
  localparam int H_TOTAL       = 1650;
  localparam int H_BLANK_START = 1280;
  localparam int H_SYNC_START  = 1390;
  localparam int V_ACTIVE      = 720;
  localparam int V_TOTAL       = 750;
  localparam int V_BLANK_START = 720;
  localparam int V_SYNC_START  = 725;

  typedef enum logic [1:0] {
    ST_DISPLAY = 2'd0,
    ST_SELECT  = 2'd1,
    ST_GRANTED = 2'd2,
    ST_DRAIN   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/vga_rr_pick.sv
// vga_rr_pick: combinational round-robin picker.
// Ports: req_i/rr_ptr_i in; win_o (one-hot), idx_o, any_o out.
module vga_rr_pick
  import vga_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    rr_ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  logic [IW-1:0] c;

  // Scan starts one past the last owner, so it becomes lowest priority.
  always_comb begin
    win_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = IW'((int'(rr_ptr_i) + k) % N_REQ);
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        idx_o    = c;
        win_o[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_vblank_arbiter.sv
// vga_vblank_arbiter: hands the frame-buffer write port to one engine at
// a time, only during vblank; also emits frame_start and frame_cnt.
// Ports: pclk, rst, vcount, vblnk, req, done in;
//        grant, busy, abort, frame_start, frame_cnt out (all registered).
module vga_vblank_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 4096,
  parameter int GUARD_LINE = 748
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [10:0]      vcount,
  input  logic             vblnk,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             abort,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);

  arb_state_e       state_q;
  logic             vblnk_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [TW-1:0]    timer_q;
  logic [N_REQ-1:0] grant_q;
  logic             busy_q;
  logic             abort_q;
  logic             fs_q;
  logic [15:0]      fcnt_q;

  logic             vs_rise;
  logic             at_guard;
  logic             own_done;
  logic             timed_out;
  logic             release_now;
  logic [N_REQ-1:0] pick_win;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  // vblnk_q resets low, so a vblank already active at reset counts
  // as a frame start.
  assign vs_rise     = vblnk & ~vblnk_q;
  assign at_guard    = vcount >= 11'(GUARD_LINE);
  // done bits of engines not holding the port are masked off here.
  assign own_done    = |(done & grant_q);
  assign timed_out   = timer_q == TW'(TIMEOUT - 1);
  assign release_now = own_done | ~vblnk | timed_out;

  vga_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req_i   (req),
    .rr_ptr_i(rr_ptr_q),
    .win_o   (pick_win),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_DISPLAY;
      vblnk_q  <= 1'b0;
      rr_ptr_q <= IW'(N_REQ - 1);
      timer_q  <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      abort_q  <= 1'b0;
      fs_q     <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      vblnk_q <= vblnk;
      fs_q    <= vs_rise;
      abort_q <= 1'b0;
      if (vs_rise) fcnt_q <= fcnt_q + 16'd1;
      unique case (state_q)
        ST_DISPLAY: begin
          if (vs_rise) state_q <= ST_SELECT;
        end
        ST_SELECT: begin
          if (!vblnk) begin
            state_q <= ST_DISPLAY;
          end else if (at_guard) begin
            state_q <= ST_DRAIN;
          end else if (pick_any) begin
            grant_q  <= pick_win;
            busy_q   <= 1'b1;
            rr_ptr_q <= pick_idx;
            timer_q  <= '0;
            state_q  <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          timer_q <= timer_q + 1'b1;
          if (release_now) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            // A clean done wins even when vblank ends in the same cycle.
            abort_q <= ~own_done;
            state_q <= vblnk ? ST_SELECT : ST_DISPLAY;
          end
        end
        ST_DRAIN: begin
          if (!vblnk) state_q <= ST_DISPLAY;
        end
        default: state_q <= ST_DISPLAY;
      endcase
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign abort       = abort_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_vblank_arbiter.sv
// tb_vga_vblank_arbiter: scoreboard bench with compressed video timing.
// A transaction-level model predicts every output cycle.
module tb_vga_vblank_arbiter;

  localparam int N     = 4;
  localparam int TO    = 16;
  localparam int GUARD = 748;
  localparam int NF    = 20;

  logic          pclk = 1'b0;
  logic          rst  = 1'b1;
  logic [10:0]   vcount;
  logic          vblnk;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  grant;
  logic          busy;
  logic          abort;
  logic          frame_start;
  logic [15:0]   frame_cnt;

  vga_vblank_arbiter #(
    .N_REQ     (N),
    .TIMEOUT   (TO),
    .GUARD_LINE(GUARD)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .vcount     (vcount),
    .vblnk      (vblnk),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .busy       (busy),
    .abort      (abort),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  always #5 pclk = ~pclk;

  typedef logic [N+3+16-1:0] obs_t;
  obs_t exp_q[$];
  obs_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
  endtask

  // Reference model: who owns the port, how long it has held it, whether
  // this blanking interval may still hand out a grant, and who went last.
  int          owner;
  int          held;
  int          last;
  bit          hunting;
  bit          prev_vb;
  logic [15:0] m_fc;

  task automatic model_reset();
    owner   = -1;
    held    = 0;
    last    = N - 1;
    hunting = 0;
    prev_vb = 0;
    m_fc    = 0;
  endtask

  task automatic model_step();
    bit         vs;
    bit         ab;
    bit         got;
    logic [1:0] c;
    logic [N-1:0] g;
    vs  = vblnk && !prev_vb;
    ab  = 0;
    got = 0;
    c   = '0;
    if (owner >= 0) begin
      held++;
      if (done[2'(owner)]) begin
        owner   = -1;
        hunting = vblnk;
      end else if (!vblnk || held == TO) begin
        owner   = -1;
        ab      = 1;
        hunting = vblnk;
      end
    end else if (hunting) begin
      if (!vblnk || vcount >= 11'(GUARD)) begin
        hunting = 0;
      end else if (req != 0) begin
        for (int k = 1; k <= N; k++) begin
          c = 2'((last + k) % N);
          if (!got && req[c]) begin
            got   = 1;
            owner = int'(c);
          end
        end
        last = owner;
        held = 0;
      end
    end
    if (vs) begin
      hunting = 1;
      m_fc++;
    end
    prev_vb = vblnk;
    g = (owner >= 0) ? 4'(1 << owner) : '0;
    exp_q.push_back({g, |g, ab, vs, m_fc});
  endtask

  always @(negedge pclk) begin
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("cycle_out", {grant, busy, abort, frame_start, frame_cnt}, mon_e);
    end
  end

  task automatic check_zero(string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_abort"}, abort, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_fcnt"}, frame_cnt, 0);
  endtask

  initial begin
    int           vc;
    int           sub;
    int           frame;
    bit           did_rst;
    logic [N-1:0] rq;
    logic [N-1:0] oh;
    int           r;
    vc      = 710;
    sub     = 0;
    frame   = 0;
    did_rst = 0;
    rq      = '0;
    vcount  = 11'(vc);
    vblnk   = 1'b0;
    req     = '0;
    done    = '0;
    model_reset();
    #2 check_zero("por");
    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;
    while (frame < NF) begin
      @(posedge pclk);
      model_step();
      #1;
      sub++;
      if (sub == ((vc >= 720) ? 4 : 1)) begin
        sub = 0;
        vc  = (vc == 749) ? 0 : vc + 1;
        if (vc == 720) frame++;
      end
      vcount = 11'(vc);
      vblnk  = vc >= 720;
      oh     = (owner >= 0) ? 4'(1 << owner) : '0;
      case (frame)
        0, 1: begin
          req  = (frame == 0) ? 4'b0001 : 4'b1111;
          done = (owner >= 0 && held == 2) ? oh : '0;
        end
        2: begin
          req  = 4'b0100;
          done = '0;
        end
        3, 4: begin
          req  = (vc >= 747 || vc < 720) ? 4'b0100 : '0;
          done = (frame == 4 && vc == 0) ? oh : '0;
        end
        5: begin
          req  = (vc >= 748 || vc < 720) ? 4'b0010 : '0;
          done = '0;
        end
        6: begin
          req  = 4'b0010;
          done = ~oh;
        end
        default: begin
          if ($urandom_range(0, 7) == 0) rq = 4'($urandom);
          req = rq;
          r   = int'($urandom_range(0, 9));
          if (r < 3) done = oh;
          else if (r == 3) done = 4'($urandom);
          else done = '0;
        end
      endcase
      if (frame == 0 && !did_rst && owner >= 0 && held == 2) begin
        did_rst = 1;
        exp_q.delete();
        rst = 1'b1;
        #1 check_zero("rst_mid");
        @(posedge pclk);
        #1 rst = 1'b0;
        model_reset();
      end
    end
    repeat (3) @(posedge pclk);
    #6;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
